// File: rtl/rst_seq_wdog.sv
// Board reset synchroniser, staged release of NUM_CH reset domains, and a
// cycle watchdog with sticky error/timeout monitoring.
module rst_seq_wdog #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 2,
   parameter int STAGE_GAP   = 1,
   parameter int CNT_W       = 32,
   parameter int MAX_CYCLES  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              err,
   output logic [NUM_CH-1:0] ch_rst,
   output logic              ready,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              timeout,
   output logic              err_flag,
   output logic              halt
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_CYCLES);
   // Single channel or zero gap: channel 0's release edge frees every channel.
   localparam bit ALL_AT_ONCE = (NUM_CH == 1) || (STAGE_GAP == 0);

   typedef enum logic [2:0] {SYNC, HOLD, RELEASE, RUN, HALT} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [HW-1:0]          hold_cnt;
   logic [GW-1:0]          gap_cnt;
   logic [IW-1:0]          idx;
   logic                   sync_done;
   logic                   rel0, rel_step, rel_last;
   logic                   tmo_hit, err_hit;
   logic [CNT_W-1:0]       cnt_inc;

   assign sync_done = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   // The edge that leaves SYNC already counts as the first hold edge.
   always_comb begin
      rel0     = 1'b0;
      rel_step = 1'b0;
      rel_last = 1'b0;
      if (state_q == SYNC && sync_done && HOLD_CYCLES == 1) rel0 = 1'b1;
      if (state_q == HOLD && hold_cnt == HW'(HOLD_CYCLES - 1)) rel0 = 1'b1;
      if (state_q == RELEASE && gap_cnt == GW'(STAGE_GAP - 1)) rel_step = 1'b1;
      if (rel_step && idx == IW'(NUM_CH - 1)) rel_last = 1'b1;
   end

   always_comb begin
      cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
      tmo_hit = (state_q == RUN) && (MAX_CYCLES != 0) && (cnt_inc == MAXV);
      err_hit = (state_q == RUN) && err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= SYNC;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (sync_done) state_d = rel0 ? (ALL_AT_ONCE ? RUN : RELEASE) : HOLD;
         HOLD:    if (rel0) state_d = ALL_AT_ONCE ? RUN : RELEASE;
         RELEASE: if (rel_last) state_d = RUN;
         RUN:     if (tmo_hit || err_hit) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = SYNC;
      endcase
   end

   always_comb begin
      ready = (state_q == RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt    <= '0;
         gap_cnt     <= '0;
         idx         <= '0;
         ch_rst      <= '1;
         cycle_count <= '0;
         timeout     <= 1'b0;
         err_flag    <= 1'b0;
         halt        <= 1'b0;
      end else begin
         if (state_q == SYNC && sync_done) hold_cnt <= HW'(1);
         else if (state_q == HOLD)         hold_cnt <= hold_cnt + HW'(1);

         if (rel0) begin
            idx     <= IW'(1);
            gap_cnt <= '0;
            if (ALL_AT_ONCE) ch_rst <= '0;
            else             ch_rst <= ch_rst & ~NUM_CH'(1);
         end else if (state_q == RELEASE) begin
            if (rel_step) begin
               ch_rst  <= ch_rst & ~(NUM_CH'(1) << idx);
               idx     <= idx + IW'(1);
               gap_cnt <= '0;
            end else begin
               gap_cnt <= gap_cnt + GW'(1);
            end
         end

         if (state_q == RUN) cycle_count <= cnt_inc;
         if (tmo_hit) timeout  <= 1'b1;
         if (err_hit) err_flag <= 1'b1;
         if (tmo_hit || err_hit) halt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Directed bench: five parameterisations share clk/rst; a sorted vector table
// is replayed per release, with hand-written async-reset checks in between.
module tb_rst_seq_wdog;

   logic clk = 1'b0;
   logic rst;
   logic err_b = 1'b0, err_f = 1'b0;
   int   ecount;
   int   n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst)
      if (!rst) ecount <= 0;
      else      ecount <= ecount + 1;

   logic [3:0] chA, chB, chD, chF;
   logic [0:0] chC;
   logic [31:0] cntA, cntB, cntC, cntF;
   logic [3:0]  cntD;
   logic rdyA, tmoA, efA, hlA, rdyB, tmoB, efB, hlB, rdyC, tmoC, efC, hlC;
   logic rdyD, tmoD, efD, hlD, rdyF, tmoF, efF, hlF;

   rst_seq_wdog #(.MAX_CYCLES(10)) uA (.clk(clk), .rst(rst), .err(1'b0), .ch_rst(chA),
      .ready(rdyA), .cycle_count(cntA), .timeout(tmoA), .err_flag(efA), .halt(hlA));
   rst_seq_wdog uB (.clk(clk), .rst(rst), .err(err_b), .ch_rst(chB),
      .ready(rdyB), .cycle_count(cntB), .timeout(tmoB), .err_flag(efB), .halt(hlB));
   rst_seq_wdog #(.NUM_CH(1), .STAGE_GAP(0), .SYNC_STAGES(3), .HOLD_CYCLES(1)) uC (
      .clk(clk), .rst(rst), .err(1'b0), .ch_rst(chC),
      .ready(rdyC), .cycle_count(cntC), .timeout(tmoC), .err_flag(efC), .halt(hlC));
   rst_seq_wdog #(.MAX_CYCLES(0), .CNT_W(4)) uD (.clk(clk), .rst(rst), .err(1'b0), .ch_rst(chD),
      .ready(rdyD), .cycle_count(cntD), .timeout(tmoD), .err_flag(efD), .halt(hlD));
   rst_seq_wdog #(.MAX_CYCLES(10)) uF (.clk(clk), .rst(rst), .err(err_f), .ch_rst(chF),
      .ready(rdyF), .cycle_count(cntF), .timeout(tmoF), .err_flag(efF), .halt(hlF));

   typedef struct {
      int          ed;
      int          id;
      logic [3:0]  ch;
      logic        rdy, tmo, ef, hl;
      logic [31:0] cnt;
   } vec_t;

   vec_t v[$];

   function automatic vec_t mk(int ed, int id, logic [3:0] ch, logic rdy, logic tmo,
                               logic ef, logic hl, int cnt);
      vec_t r;
      r.ed = ed; r.id = id; r.ch = ch; r.rdy = rdy; r.tmo = tmo; r.ef = ef; r.hl = hl;
      r.cnt = 32'(cnt);
      return r;
   endfunction

   function automatic logic [39:0] act(int id);
      case (id)
         0:       return {chA, rdyA, tmoA, efA, hlA, cntA};
         1:       return {chB, rdyB, tmoB, efB, hlB, cntB};
         2:       return {3'b000, chC, rdyC, tmoC, efC, hlC, cntC};
         3:       return {chD, rdyD, tmoD, efD, hlD, 28'd0, cntD};
         default: return {chF, rdyF, tmoF, efF, hlF, cntF};
      endcase
   endfunction

   task automatic check(string nm, logic [39:0] a, logic [39:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got ch=%b rdy=%b tmo=%b ef=%b hlt=%b cnt=%0d, want ch=%b rdy=%b tmo=%b ef=%b hlt=%b cnt=%0d",
                  nm, a[39:36], a[35], a[34], a[33], a[32], a[31:0],
                  e[39:36], e[35], e[34], e[33], e[32], e[31:0]);
      end
   endtask

   task automatic reset_checks(string tag);
      for (int id = 0; id < 5; id++)
         check($sformatf("%s_id%0d", tag, id), act(id),
               {(id == 2) ? 4'b0001 : 4'b1111, 4'b0000, 32'd0});
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic run_table(string tag);
      int guard = 0;
      @(negedge clk);
      for (int i = 0; i < v.size(); i++) begin
         while (ecount < v[i].ed && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 5000) begin
            n_vec++; n_bad++;
            $display("FAIL %s_edge_wait: got edge %0d, want %0d", tag, ecount, v[i].ed);
            return;
         end
         check($sformatf("%s_v%0d_id%0d_e%0d", tag, i, v[i].id, v[i].ed), act(v[i].id),
               {v[i].ch, v[i].rdy, v[i].tmo, v[i].ef, v[i].hl, v[i].cnt});
      end
   endtask

   // err for uB: edges 1..6 (masked, pre-RUN) and edge 12; for uF: edge 17 only.
   initial forever begin
      @(negedge clk);
      err_b = rst && ((ecount + 1 <= 6) || (ecount + 1 == 12));
      err_f = rst && (ecount + 1 == 17);
   end

   initial begin
      //            ed  id  ch      rdy tmo ef hl cnt
      v.push_back(mk(0,    0, 4'b1111, 0, 0, 0, 0, 0));
      v.push_back(mk(0,    2, 4'b0001, 0, 0, 0, 0, 0));
      v.push_back(mk(3,    0, 4'b1111, 0, 0, 0, 0, 0));
      v.push_back(mk(3,    2, 4'b0001, 0, 0, 0, 0, 0));
      v.push_back(mk(4,    0, 4'b1110, 0, 0, 0, 0, 0));
      v.push_back(mk(4,    2, 4'b0000, 1, 0, 0, 0, 0));
      v.push_back(mk(5,    0, 4'b1100, 0, 0, 0, 0, 0));
      v.push_back(mk(5,    2, 4'b0000, 1, 0, 0, 0, 1));
      v.push_back(mk(6,    0, 4'b1000, 0, 0, 0, 0, 0));
      v.push_back(mk(6,    1, 4'b1000, 0, 0, 0, 0, 0));
      v.push_back(mk(7,    0, 4'b0000, 1, 0, 0, 0, 0));
      v.push_back(mk(7,    1, 4'b0000, 1, 0, 0, 0, 0));
      v.push_back(mk(7,    3, 4'b0000, 1, 0, 0, 0, 0));
      v.push_back(mk(8,    0, 4'b0000, 1, 0, 0, 0, 1));
      v.push_back(mk(11,   1, 4'b0000, 1, 0, 0, 0, 4));
      v.push_back(mk(12,   1, 4'b0000, 0, 0, 1, 1, 5));
      v.push_back(mk(15,   1, 4'b0000, 0, 0, 1, 1, 5));
      v.push_back(mk(16,   0, 4'b0000, 1, 0, 0, 0, 9));
      v.push_back(mk(16,   4, 4'b0000, 1, 0, 0, 0, 9));
      v.push_back(mk(17,   0, 4'b0000, 0, 1, 0, 1, 10));
      v.push_back(mk(17,   4, 4'b0000, 0, 1, 1, 1, 10));
      v.push_back(mk(20,   0, 4'b0000, 0, 1, 0, 1, 10));
      v.push_back(mk(21,   3, 4'b0000, 1, 0, 0, 0, 14));
      v.push_back(mk(22,   3, 4'b0000, 1, 0, 0, 0, 15));
      v.push_back(mk(30,   3, 4'b0000, 1, 0, 0, 0, 15));
      v.push_back(mk(1003, 2, 4'b0000, 1, 0, 0, 0, 999));
      v.push_back(mk(1004, 2, 4'b0000, 0, 1, 0, 1, 1000));

      rst = 1'b1;
      #3 rst = 1'b0;
      #10 reset_checks("por");
      release_rst();
      run_table("run1");

      // Several instances are in HALT here; async clear must act without clk.
      #1 rst = 1'b0;
      #1 reset_checks("rst_halt");
      release_rst();
      while (ecount < 5) @(negedge clk);
      #1 rst = 1'b0;
      #1 reset_checks("rst_release");
      release_rst();
      run_table("run2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rst_seq_wdog.md
# rst_seq_wdog

Parametrised, synthesizable successor to the simulation clock/reset generator. It takes the board-level asynchronous reset and synchronises its release. It then releases NUM_CH downstream reset domains in staged order and runs a cycle watchdog with a sticky error monitor. It sits at the top of the processor wrapper, between the external reset pin and the per-unit reset inputs (fetch, decode, memory, and so on).

## Interface
- NUM_CH, 4: number of sequenced reset channels (1..16)
- SYNC_STAGES, 2: reset-release synchroniser depth (>=2)
- HOLD_CYCLES, 2: cycles all channels stay in reset after the synchronised release (>=1)
- STAGE_GAP, 1: cycles between consecutive channel releases (0 = release all channels together)
- CNT_W, 32: cycle counter width
- MAX_CYCLES, 1000: watchdog limit; 0 disables the watchdog

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- err  in  1  error indication from the design; sampled on rising clk
- ch_rst  out  NUM_CH  per-channel reset, active-high
- ready  out  1  all channels released and not halted
- cycle_count  out  CNT_W  clk cycles spent in RUN
- timeout  out  1  sticky; watchdog limit reached
- err_flag  out  1  sticky; err seen in RUN
- halt  out  1  sticky; timeout | err_flag

## Operation
- **Reset (rst=0):**
  - The asynchronous clear forces all state to the values below, without waiting for clk.
  - Synchroniser = 0, state = SYNC, ch_rst = all ones.
  - ready = 0, cycle_count = 0, timeout = 0, err_flag = 0, halt = 0.
- **Synchroniser:** a SYNC_STAGES-deep flop chain shifts in 1 while rst=1. Its last stage is the synchronised release.
- **FSM states:**
  - SYNC: wait until the last synchroniser stage is 1, then go to HOLD.
  - HOLD: count HOLD_CYCLES edges, then release ch_rst[0] and go to RELEASE.
  - RELEASE: release ch_rst[i] STAGE_GAP edges after ch_rst[i-1], in ascending index order. After the last channel is released, go to RUN.
  - RUN: cycle_count increments every edge and saturates at all ones. err and the watchdog are monitored only in this state.
  - HALT: terminal state; exit only through rst.
- **Masking:** err outside RUN is ignored.
- **Error:** err=1 sampled in RUN sets err_flag and halt, and the FSM goes to HALT.
- **Watchdog:** when MAX_CYCLES≠0 and cycle_count becomes MAX_CYCLES, timeout and halt set and the FSM goes to HALT.
- **Simultaneous err and timeout on the same edge:** timeout, err_flag and halt all set.
- **In HALT:**
  - cycle_count is frozen.
  - ch_rst stays released (state remains inspectable).
  - ready = 0.
- **Single-channel and zero-gap cases:**
  - With NUM_CH=1, ch_rst[0] releases and RUN is entered on the same edge.
  - With STAGE_GAP=0, all channels release on the same edge.
- **Reset mid-operation:** rst=0 in any state immediately re-asserts every ch_rst and clears all flags and the counter. The full sequence restarts on release.

## Timing
- Number rising clk edges at which rst is sampled 1 as 1, 2, 3, …
- ch_rst[i] falls at edge SYNC_STAGES + HOLD_CYCLES + i·STAGE_GAP. With defaults:
  - ch_rst[0] at edge 4, ch_rst[1] at edge 5, ch_rst[2] at edge 6, ch_rst[3] at edge 7.
- RUN is entered, and ready rises, at the edge that releases the last channel. cycle_count is 0 at that edge and is 1 one edge later.
- timeout and halt rise at the edge where cycle_count reaches MAX_CYCLES. With defaults that is 1000 edges after RUN entry, edge 1007.
- err is sampled at edge k in RUN → err_flag, halt = 1 and ready = 0 after edge k. cycle_count holds the value it reached at edge k.
- rst falling edge → ch_rst = all ones combinationally via async clear, with no clk edge needed.
- Outputs are registered; no output has a combinational path from err.

## Test plan
- **Defaults, release sequence:** release rst 1 ns after a posedge → ch_rst = 1111 through edge 3, then 1110 at edge 4, 1100 at edge 5, 1000 at edge 6, 0000 at edge 7. ready=1 from edge 7.
- **Watchdog:** MAX_CYCLES=10, err=0 → timeout=halt=1 at edge 17, cycle_count=10 frozen afterwards, ch_rst stays 0000.
- **Error masking and capture:**
  - err=1 during edges 1–6 → no err_flag.
  - err=1 at edge 12 only → err_flag=halt=1 after edge 12, cycle_count=5, stays sticky.
- **Simultaneous events:** MAX_CYCLES=10 with err=1 at edge 17 → timeout, err_flag and halt all 1.
- **Reset mid-operation:** rst=0 between edges (mid-RELEASE and again in HALT) → ch_rst=1111 and all flags/counter 0 before the next edge; the sequence repeats identically after release.
- **Parameter corners:**
  - NUM_CH=1, STAGE_GAP=0, SYNC_STAGES=3, HOLD_CYCLES=1 → ch_rst[0] falls at edge 4 with ready=1 at the same edge.
  - MAX_CYCLES=0, CNT_W=4 → cycle_count saturates at 15 and no timeout ever.
